// File: rtl/fifo_xbar_pkg.sv
// Shared helpers for the fifo_xbar crossbar: map-entry width, reset map, slice math.
// Latency: n/a (elaboration-time and combinational helpers only).
// Backpressure: n/a.
package fifo_xbar_pkg;

    localparam int MAX_CH    = 8;
    localparam int MAX_SEL_W = 3;
    localparam int MAP_MAX_W = MAX_CH * MAX_SEL_W;

    // Width of one map entry: enough bits to name any of n channels, never zero.
    function automatic int sel_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    // Low bit of entry idx inside a packed vector of w-bit entries.
    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

    // Reset routing: input i drives output (i mod num_out), packed at sel_width(num_out) bits per entry.
    function automatic logic [MAP_MAX_W-1:0] default_map(input int num_in, input int num_out);
        logic [MAP_MAX_W-1:0] m;
        int                   sw;
        int                   dst;
        m  = '0;
        sw = sel_width(num_out);
        for (int i = 0; i < MAX_CH; i++) begin
            dst = i % num_out;
            for (int b = 0; b < MAX_SEL_W; b++) begin
                if ((i < num_in) && (b < sw)) begin
                    m[i * sw + b] = dst[b];
                end
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/fifo_xbar_fifo.sv
// Synchronous FIFO buffering one crossbar input channel.
// Latency: a pushed word is readable at pop_dat_o the cycle after the push edge.
// Backpressure: full_o blocks further pushes; pushes while full and pops while empty are ignored.
module fifo_xbar_fifo #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 4,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_dat_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] pop_dat_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [CNT_W-1:0]  count_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign pop_dat_o = mem_q[rd_ptr_q];
    assign do_push   = push_i && !full_o;
    assign do_pop    = pop_i && !empty_o;

    // Pointer advance (wraps naturally since DEPTH is a power of two) and occupancy tracking.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; reset flushes the queue by zeroing pointers and count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/fifo_xbar.sv
// NUM_IN buffered inputs routed by a runtime map to NUM_OUT registered outputs, round-robin per output.
// Latency: 1 cycle from input accept to data_out_vld on an idle output; 1 word/cycle sustained per output.
// Backpressure: per-input FIFO full or pending cfg_vld drops data_in_rdy; stalled outputs hold data and vld.
module fifo_xbar
    import fifo_xbar_pkg::*;
#(
    parameter int NUM_IN  = 2,
    parameter int NUM_OUT = 2,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int SEL_W   = sel_width(NUM_OUT)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_IN*DATA_W-1:0]  data_in,
    input  logic [NUM_IN-1:0]         data_in_vld,
    output logic [NUM_IN-1:0]         data_in_rdy,
    output logic [NUM_OUT*DATA_W-1:0] data_out,
    output logic [NUM_OUT-1:0]        data_out_vld,
    input  logic [NUM_OUT-1:0]        data_out_rdy,
    input  logic [NUM_IN*SEL_W-1:0]   cfg_map,
    input  logic                      cfg_vld,
    output logic                      cfg_rdy,
    output logic [NUM_IN*SEL_W-1:0]   map_cur,
    output logic [NUM_IN-1:0]         fifo_empty
);

    localparam int                   MAP_W       = NUM_IN * SEL_W;
    localparam int                   IDX_W       = sel_width(NUM_IN);
    localparam int                   CNT_W       = $clog2(DEPTH) + 1;
    localparam logic [MAP_MAX_W-1:0] MAP_RST_ALL = default_map(NUM_IN, NUM_OUT);

    logic [NUM_IN-1:0] full;
    logic [NUM_IN-1:0] empty;
    logic [NUM_IN-1:0] push;
    logic [NUM_IN-1:0] pop;
    logic [NUM_IN-1:0] drained;
    logic [DATA_W-1:0] fifo_dat [NUM_IN];
    logic [CNT_W-1:0]  fifo_cnt [NUM_IN];
    logic [NUM_IN-1:0] gnt      [NUM_OUT];
    logic [MAP_W-1:0]  map_q, map_d;

    // Holding off every input while a map change is pending lets the block drain.
    assign data_in_rdy = ~full & {NUM_IN{!cfg_vld}};
    assign push        = data_in_vld & data_in_rdy;
    assign fifo_empty  = empty;
    assign map_cur     = map_q;
    assign cfg_rdy     = cfg_vld && !rst && (&drained) && !(|data_out_vld);

    for (genvar i = 0; i < NUM_IN; i++) begin : g_in
        assign drained[i] = (fifo_cnt[i] == '0);

        fifo_xbar_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk        (clk),
            .rst        (rst),
            .push_i     (push[i]),
            .push_dat_i (data_in[i*DATA_W +: DATA_W]),
            .pop_i      (pop[i]),
            .pop_dat_o  (fifo_dat[i]),
            .full_o     (full[i]),
            .empty_o    (empty[i]),
            .count_o    (fifo_cnt[i])
        );
    end

    // Each input is routed to exactly one output, so at most one grant term is set per input.
    always_comb begin
        pop = '0;
        for (int o = 0; o < NUM_OUT; o++) begin
            pop = pop | gnt[o];
        end
    end

    // Swap in the requested map only once everything has drained.
    always_comb begin
        map_d = map_q;
        if (cfg_vld && cfg_rdy) begin
            map_d = cfg_map;
        end
    end

    // Active map register; reset restores the i mod NUM_OUT routing even if cfg_vld is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            map_q <= MAP_RST_ALL[MAP_W-1:0];
        end else begin
            map_q <= map_d;
        end
    end

    for (genvar o = 0; o < NUM_OUT; o++) begin : g_out
        logic [NUM_IN-1:0] req;
        logic [IDX_W-1:0]  win;
        logic              found;
        logic              load;
        logic [IDX_W-1:0]  rr_q, rr_d;
        logic              ovld_q, ovld_d;
        logic [DATA_W-1:0] odat_q, odat_d;

        // Inputs routed here with data waiting; entries naming a nonexistent output never match.
        always_comb begin
            req = '0;
            for (int i = 0; i < NUM_IN; i++) begin
                req[i] = !empty[i] && (map_q[slice_lo(i, SEL_W) +: SEL_W] == SEL_W'(o));
            end
        end

        // Round-robin search: first requester at or after rr_q, wrapping.
        always_comb begin
            int idx;
            found = 1'b0;
            win   = '0;
            idx   = 0;
            for (int k = 0; k < NUM_IN; k++) begin
                idx = (int'(rr_q) + k) % NUM_IN;
                if (!found && req[idx]) begin
                    found = 1'b1;
                    win   = IDX_W'(idx);
                end
            end
        end

        // The output register accepts a new word whenever it is empty or being drained this cycle.
        assign load   = !ovld_q || data_out_rdy[o];
        assign gnt[o] = (load && found) ? (NUM_IN'(1) << win) : '0;

        // Output register next state; the pointer moves past the winner only on a grant.
        always_comb begin
            rr_d   = rr_q;
            ovld_d = ovld_q;
            odat_d = odat_q;
            if (load) begin
                ovld_d = found;
                if (found) begin
                    odat_d = fifo_dat[win];
                    rr_d   = IDX_W'((int'(win) + 1) % NUM_IN);
                end
            end
        end

        // Output register and arbitration pointer state.
        always_ff @(posedge clk) begin
            if (rst) begin
                rr_q   <= '0;
                ovld_q <= 1'b0;
                odat_q <= '0;
            end else begin
                rr_q   <= rr_d;
                ovld_q <= ovld_d;
                odat_q <= odat_d;
            end
        end

        assign data_out_vld[o]               = ovld_q;
        assign data_out[o*DATA_W +: DATA_W] = odat_q;
    end

endmodule

// File: tb/tb_fifo_xbar.sv
module tb_fifo_xbar;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    // 2x2, 32-bit, depth 4 instance
    logic [63:0] din;
    logic [1:0]  din_vld, din_rdy;
    logic [63:0] dout;
    logic [1:0]  dout_vld, dout_rdy;
    logic [1:0]  cfg_map, map_cur;
    logic        cfg_vld, cfg_rdy;
    logic [1:0]  fempty;
    // 4x3, 8-bit, depth 8 instance
    logic [31:0] din4;
    logic [3:0]  din_vld4, din_rdy4;
    logic [23:0] dout4;
    logic [2:0]  dout_vld4, dout_rdy4;
    logic [7:0]  cfg_map4, map_cur4;
    logic        cfg_vld4, cfg_rdy4;
    logic [3:0]  fempty4;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] got0 [$];
    logic [31:0] got1 [$];
    int          cyc0 [$];
    logic [7:0]  alt_q [$];
    int          tx_seq [4];
    int          rx_seq [4];
    int          rx_total;

    fifo_xbar #(.NUM_IN(2), .NUM_OUT(2), .DATA_W(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .data_in(din), .data_in_vld(din_vld), .data_in_rdy(din_rdy),
        .data_out(dout), .data_out_vld(dout_vld), .data_out_rdy(dout_rdy),
        .cfg_map(cfg_map), .cfg_vld(cfg_vld), .cfg_rdy(cfg_rdy),
        .map_cur(map_cur), .fifo_empty(fempty)
    );

    fifo_xbar #(.NUM_IN(4), .NUM_OUT(3), .DATA_W(8), .DEPTH(8)) dut4 (
        .clk(clk), .rst(rst),
        .data_in(din4), .data_in_vld(din_vld4), .data_in_rdy(din_rdy4),
        .data_out(dout4), .data_out_vld(dout_vld4), .data_out_rdy(dout_rdy4),
        .cfg_map(cfg_map4), .cfg_vld(cfg_vld4), .cfg_rdy(cfg_rdy4),
        .map_cur(map_cur4), .fifo_empty(fempty4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream n words from each 2x2 input starting at cycle d, outputs always ready; log outputs.
    task automatic run2(input int n0, input int d0, input logic [31:0] b0,
                        input int n1, input int d1, input logic [31:0] b1, input int ncyc);
        int s0, s1;
        s0 = 0;
        s1 = 0;
        got0.delete();
        got1.delete();
        cyc0.delete();
        dout_rdy = 2'b11;
        for (int c = 0; c < ncyc; c++) begin
            din_vld[0]  = (c >= d0) && (s0 < n0);
            din_vld[1]  = (c >= d1) && (s1 < n1);
            din[31:0]   = b0 + 32'(s0);
            din[63:32]  = b1 + 32'(s1);
            #1;
            if (dout_vld[0]) begin
                got0.push_back(dout[31:0]);
                cyc0.push_back(c);
            end
            if (dout_vld[1]) got1.push_back(dout[63:32]);
            if (din_vld[0] && din_rdy[0]) s0++;
            if (din_vld[1] && din_rdy[1]) s1++;
            tick();
        end
        din_vld = 2'b00;
    endtask

    // Drive the 4x3 instance; words carry {source, sequence} and are scored against default routing.
    task automatic run4(input int max_cyc, input logic [3:0] mask, input int nper,
                        input bit rnd, input int target);
        for (int c = 0; c < max_cyc && rx_total < target; c++) begin
            for (int i = 0; i < 4; i++) begin
                din_vld4[i]     = mask[i] && (tx_seq[i] < nper) &&
                                  (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
                din4[i*8 +: 8]  = {2'(i), 6'(tx_seq[i])};
            end
            dout_rdy4 = rnd ? 3'($urandom_range(0, 7)) : 3'b111;
            #1;
            for (int o = 0; o < 3; o++) begin
                if (dout_vld4[o] && dout_rdy4[o]) begin
                    logic [7:0] w;
                    int         s;
                    w = dout4[o*8 +: 8];
                    s = int'(w[7:6]);
                    chk("sb_route", 64'(o), 64'(s % 3));
                    chk("sb_seq", {58'd0, w[5:0]}, 64'(rx_seq[s] % 64));
                    if (o == 0 && !rnd) alt_q.push_back(w);
                    rx_seq[s]++;
                    rx_total++;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (din_vld4[i] && din_rdy4[i]) tx_seq[i]++;
            end
            tick();
        end
        din_vld4 = 4'b0000;
    endtask

    initial begin
        int sent, got, held_bad, waited, stale;
        logic [31:0] exp_t3 [8];
        logic [31:0] exp_t4 [8];
        logic [7:0]  exp_alt [8];
        exp_t3  = '{32'h10, 32'h20, 32'h11, 32'h21, 32'h12, 32'h22, 32'h13, 32'h23};
        exp_t4  = '{32'h50, 32'h51, 32'h52, 32'h60, 32'h53, 32'h61, 32'h54, 32'h55};
        exp_alt = '{8'h00, 8'hC0, 8'h01, 8'hC1, 8'h02, 8'hC2, 8'h03, 8'hC3};

        rst = 1'b1; cfg_vld = 1'b1; cfg_map = 2'b11;
        din = '0; din_vld = '0; dout_rdy = '0;
        din4 = '0; din_vld4 = '0; dout_rdy4 = '0; cfg_map4 = '0; cfg_vld4 = 1'b0;
        rx_total = 0;
        for (int i = 0; i < 4; i++) begin
            tx_seq[i] = 0;
            rx_seq[i] = 0;
        end

        // Reset with a map request pending: reset wins, no cfg accept.
        tick();
        chk("rst_cfg_rdy", cfg_rdy, 1'b0);
        chk("rst_empty", fempty, 2'b11);
        chk("rst_out_vld", dout_vld, 2'b00);
        chk("rst_out_dat", dout, 64'd0);
        chk("rst_in_rdy_cfg", din_rdy, 2'b00);
        tick();
        chk("rst_map_default", map_cur, 2'b10);
        chk("rst4_map_default", map_cur4, 8'h24);
        chk("rst4_empty", fempty4, 4'hF);
        chk("rst4_out_vld", dout_vld4, 3'b000);
        rst = 1'b0; cfg_vld = 1'b0;
        tick();
        chk("post_rst_map", map_cur, 2'b10);

        // Back-to-back stream on in0 -> out0, one cycle latency, out1 idle.
        din_vld = 2'b01; dout_rdy = 2'b11;
        for (int k = 0; k < 4; k++) begin
            din[31:0] = 32'hA0 + 32'(k);
            #1;
            chk("t1_in_rdy", din_rdy[0], 1'b1);
            tick();
            if (k == 0) chk("t1_first_latency", dout_vld, 2'b00);
            else        chk("t1_out0", {dout_vld, dout[31:0]}, {2'b01, 32'hA0 + 32'(k - 1)});
        end
        din_vld = 2'b00;
        tick();
        chk("t1_out0_last", {dout_vld, dout[31:0]}, {2'b01, 32'hA3});
        tick();
        chk("t1_idle", dout_vld, 2'b00);

        // Stall out0: output register plus 4 FIFO entries absorb 5 words, then input blocks.
        dout_rdy = 2'b00; sent = 0; held_bad = 0;
        for (int c = 0; c < 10; c++) begin
            din[31:0] = 32'hB0 + 32'(sent);
            din_vld   = (sent < 6) ? 2'b01 : 2'b00;
            #1;
            if (dout_vld[0] && dout[31:0] != 32'hB0) held_bad++;
            if (din_vld[0] && din_rdy[0]) sent++;
            tick();
        end
        chk("t2_accepted", 64'(sent), 64'd5);
        chk("t2_in_rdy_full", din_rdy[0], 1'b0);
        chk("t2_hold_stable", 64'(held_bad), 64'd0);
        chk("t2_out_held", {dout_vld[0], dout[31:0]}, {1'b1, 32'hB0});
        dout_rdy = 2'b01; got = 0;
        for (int c = 0; c < 20 && got < 6; c++) begin
            din[31:0] = 32'hB0 + 32'(sent);
            din_vld   = (sent < 6) ? 2'b01 : 2'b00;
            #1;
            if (dout_vld[0]) begin
                chk("t2_drain_word", dout[31:0], 32'hB0 + 32'(got));
                got++;
            end
            if (din_vld[0] && din_rdy[0]) sent++;
            tick();
        end
        din_vld = 2'b00;
        chk("t2_drain_count", 64'(got), 64'd6);

        // Map change with data in flight: inputs block, cfg_rdy only after full drain.
        dout_rdy = 2'b00; din_vld = 2'b11;
        din = {32'h40, 32'h30};
        tick();
        din = {32'h41, 32'h31};
        tick();
        din = {32'h42, 32'h32};
        cfg_map = 2'b11; cfg_vld = 1'b1;
        #1;
        chk("t3_in_blocked", din_rdy, 2'b00);
        chk("t3_cfg_wait", cfg_rdy, 1'b0);
        chk("t3_outs_held", dout, {32'h40, 32'h30});
        dout_rdy = 2'b11; waited = 0;
        for (int w = 0; w < 20; w++) begin
            if (cfg_rdy) break;
            tick();
            waited++;
        end
        chk("t3_cfg_rdy", cfg_rdy, 1'b1);
        chk("t3_drain_cycles", 64'(waited), 64'd2);
        chk("t3_drained_empty", {fempty, dout_vld}, {2'b11, 2'b00});
        chk("t3_map_not_yet", map_cur, 2'b10);
        tick();
        cfg_vld = 1'b0; din_vld = 2'b00;
        chk("t3_map_new", map_cur, 2'b11);
        run2(4, 0, 32'h10, 4, 0, 32'h20, 14);
        chk("t3_out1_count", 64'(got1.size()), 64'd8);
        chk("t3_out0_silent", 64'(got0.size()), 64'd0);
        for (int k = 0; k < 8 && k < got1.size(); k++) chk("t3_out1_order", got1[k], exp_t3[k]);

        // Both inputs onto out0: in1 alone streams without bubbles, in0 joins within 2 cycles.
        cfg_map = 2'b00; cfg_vld = 1'b1;
        #1;
        chk("t4_cfg_rdy_idle", cfg_rdy, 1'b1);
        tick();
        cfg_vld = 1'b0;
        chk("t4_map", map_cur, 2'b00);
        run2(2, 3, 32'h60, 6, 0, 32'h50, 14);
        chk("t4_out0_count", 64'(got0.size()), 64'd8);
        chk("t4_out1_unmapped", 64'(got1.size()), 64'd0);
        for (int k = 0; k < 8 && k < got0.size(); k++) begin
            chk("t4_out0_order", got0[k], exp_t4[k]);
            chk("t4_no_bubble", 64'(cyc0[k]), 64'(cyc0[0] + k));
        end

        // Reset mid-operation with 3 words buffered and out0 holding one.
        dout_rdy = 2'b00; din_vld = 2'b01;
        for (int k = 0; k < 4; k++) begin
            din[31:0] = 32'h70 + 32'(k);
            tick();
        end
        din_vld = 2'b00;
        chk("t5_pre_out", {dout_vld, dout[31:0]}, {2'b01, 32'h70});
        chk("t5_pre_empty", fempty, 2'b10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_out_vld", dout_vld, 2'b00);
        chk("t5_out_dat", dout, 64'd0);
        chk("t5_empty", fempty, 2'b11);
        chk("t5_map", map_cur, 2'b10);
        dout_rdy = 2'b11; stale = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (dout_vld != 2'b00) stale++;
        end
        chk("t5_no_stale", 64'(stale), 64'd0);

        // 4x3 build: in0 and in3 share out0 and alternate, then a random scoreboarded run.
        run4(30, 4'b1001, 4, 1'b0, 8);
        chk("t6_alt_count", 64'(alt_q.size()), 64'd8);
        for (int k = 0; k < 8 && k < alt_q.size(); k++) chk("t6_alt_order", alt_q[k], exp_alt[k]);
        run4(3000, 4'b1111, 100000, 1'b1, 208);
        chk("t6_random_total", 64'(rx_total >= 208), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
